control_unit: RTL and testbench

Sequencing controller for the programmable processor. It owns the program counter and instruction register, and fetches 16-bit instructions from instruction memory. It decodes each instruction and drives the register-file, data-memory and ALU select controls, so it sits directly upstream of the ALU and produces its 3-bit function select every instruction. It is a Moore FSM: outputs are a function of state and IR only.

---
 rtl/control_unit.sv | 127 ++++++++++++
 tb/tb_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: Moore sequencing FSM owning PC/IR; decodes 16-bit instructions into RF, data-memory and ALU controls.
//   clk, reset      : rising-edge clock, synchronous active-high reset (INIT, PC=0, IR=0)
//   im_data         : instruction memory read data (combinational ROM addressed by pc_addr)
//   pc_addr         : program counter, instruction memory address
//   d_addr, d_wr    : data memory address and write enable
//   rf_s            : register-file write-data select (1 = data memory, 0 = ALU)
//   rf_w_en, rf_w_addr, rf_ra_addr, rf_rb_addr : register-file controls
//   alu_s           : ALU function select
//   state           : current state encoding, debug only
module control_unit #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     im_data,
    output logic [PC_W-1:0] pc_addr,
    output logic [7:0]      d_addr,
    output logic            d_wr,
    output logic            rf_s,
    output logic            rf_w_en,
    output logic [3:0]      rf_w_addr,
    output logic [3:0]      rf_ra_addr,
    output logic [3:0]      rf_rb_addr,
    output logic [2:0]      alu_s,
    output logic [3:0]      state
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ALU    = 4'd7,
        HALT   = 4'd8
    } state_t;

    state_t          st, nxt;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      op;

    assign op      = ir[15:12];
    assign pc_addr = pc;
    assign state   = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= INIT;
            pc <= '0;
            ir <= '0;
        end else begin
            st <= nxt;
            if (st == INIT)
                pc <= '0;
            if (st == FETCH) begin
                ir <= im_data;
                pc <= pc + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            INIT:   nxt = FETCH;
            FETCH:  nxt = DECODE;
            DECODE:
                case (op)
                    4'd1:                                    nxt = STORE;
                    4'd2:                                    nxt = LOAD_A;
                    4'd5:                                    nxt = HALT;
                    4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: nxt = ALU;
                    default:                                 nxt = NOOP;
                endcase
            LOAD_A: nxt = LOAD_B;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_en    = 1'b0;
        rf_w_addr  = '0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s      = '0;
        case (st)
            STORE: begin
                d_addr     = ir[7:0];
                rf_ra_addr = ir[11:8];
                d_wr       = 1'b1;
            end
            LOAD_A: begin
                d_addr = ir[11:4];
                rf_s   = 1'b1;
            end
            LOAD_B: begin
                d_addr    = ir[11:4];
                rf_s      = 1'b1;
                rf_w_addr = ir[3:0];
                rf_w_en   = 1'b1;
            end
            ALU: begin
                rf_ra_addr = ir[11:8];
                rf_rb_addr = ir[7:4];
                rf_w_addr  = ir[3:0];
                rf_w_en    = 1'b1;
                case (op)
                    4'd3:    alu_s = 3'd1;
                    4'd4:    alu_s = 3'd2;
                    4'd6:    alu_s = 3'd4;
                    4'd7:    alu_s = 3'd5;
                    4'd8:    alu_s = 3'd6;
                    4'd9:    alu_s = 3'd7;
                    4'd10:   alu_s = 3'd3;
                    default: alu_s = 3'd0;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit driving a small instruction ROM.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] im_data;
    logic [6:0]  pc_addr;
    logic [7:0]  d_addr;
    logic        d_wr, rf_s, rf_w_en;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [2:0]  alu_s;
    logic [3:0]  state;

    logic [15:0] rom [128];
    logic [2:0]  alu_map [16];
    int          cmp = 0;
    int          errs = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] pc;
        logic [7:0] da;
        logic       dw;
        logic       rs;
        logic       we;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] as;
    } vec_t;

    vec_t q[$];

    assign im_data = rom[pc_addr];

    always #5 clk = ~clk;

    control_unit #(.PC_W(7)) dut (
        .clk(clk), .reset(reset), .im_data(im_data), .pc_addr(pc_addr),
        .d_addr(d_addr), .d_wr(d_wr), .rf_s(rf_s), .rf_w_en(rf_w_en),
        .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .alu_s(alu_s), .state(state)
    );

    function automatic vec_t v(input logic [3:0] s, input logic [6:0] p);
        vec_t r;
        r = '0;
        r.st = s;
        r.pc = p;
        return r;
    endfunction

    task automatic cyc(input string tag);
        vec_t e, g;
        @(negedge clk);
        g = {state, pc_addr, d_addr, d_wr, rf_s, rf_w_en, rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s};
        cmp++;
        if (q.size() == 0) begin
            errs++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, g);
        end else begin
            e = q.pop_front();
            assert (g === e) else begin
                errs++;
                $error("FAIL %s: observed %h expected %h", tag, g, e);
            end
        end
        cmp++;
        assert ((d_wr & rf_w_en) === 1'b0) else begin
            errs++;
            $error("FAIL %s_wr_hazard: observed d_wr=%b rf_w_en=%b expected not both 1", tag, d_wr, rf_w_en);
        end
    endtask

    task automatic run(input logic [6:0] p, input string tag, output logic [6:0] pn);
        logic [15:0] ir;
        logic [3:0]  op;
        vec_t        e;
        ir = rom[p];
        op = ir[15:12];
        pn = p + 7'd1;
        q.push_back(v(4'd1, p));
        cyc({tag, "_fetch"});
        q.push_back(v(4'd2, pn));
        cyc({tag, "_decode"});
        e = v(4'd3, pn);
        if (op == 4'd2) begin
            e.st = 4'd4;
            e.da = ir[11:4];
            e.rs = 1'b1;
            q.push_back(e);
            cyc({tag, "_load_a"});
            e.st = 4'd5;
            e.we = 1'b1;
            e.wa = ir[3:0];
        end else if (op == 4'd1) begin
            e.st = 4'd6;
            e.da = ir[7:0];
            e.ra = ir[11:8];
            e.dw = 1'b1;
        end else if (op == 4'd5) begin
            e.st = 4'd8;
        end else if (alu_map[op] != 3'd0) begin
            e.st = 4'd7;
            e.ra = ir[11:8];
            e.rb = ir[7:4];
            e.wa = ir[3:0];
            e.we = 1'b1;
            e.as = alu_map[op];
        end
        q.push_back(e);
        cyc({tag, "_exec"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] p;
        vec_t       e;
        for (int i = 0; i < 16; i++) alu_map[i] = 3'd0;
        alu_map[3] = 3'd1; alu_map[4] = 3'd2; alu_map[6] = 3'd4; alu_map[7] = 3'd5;
        alu_map[8] = 3'd6; alu_map[9] = 3'd7; alu_map[10] = 3'd3;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h3125; rom[1] = 16'h4125; rom[2] = 16'h6125; rom[3] = 16'h7125;
        rom[4] = 16'h8125; rom[5] = 16'h9125; rom[6] = 16'hA125; rom[7] = 16'h2AB7;
        rom[8] = 16'h13C4; rom[9] = 16'hF000; rom[10] = 16'hB3C4; rom[11] = 16'h5000;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        q.push_back(v(4'd0, 7'd0));
        cyc("reset");
        reset = 1'b0;

        p = 7'd0;
        for (int i = 0; i < 12; i++) run(p, "prog", p);
        for (int i = 0; i < 20; i++) begin
            q.push_back(v(4'd8, 7'd12));
            cyc("halt_hold");
        end

        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        reset = 1'b1;
        q.push_back(v(4'd0, 7'd0));
        cyc("halt_reset");
        reset = 1'b0;

        p = 7'd0;
        for (int i = 0; i < 129; i++) run(p, "wrap", p);

        reset = 1'b1;
        q.push_back(v(4'd0, 7'd0));
        cyc("reset2");
        reset = 1'b0;
        rom[0] = 16'h2AB7;
        q.push_back(v(4'd1, 7'd0));
        cyc("ml_fetch");
        q.push_back(v(4'd2, 7'd1));
        cyc("ml_decode");
        e = v(4'd4, 7'd1);
        e.da = 8'hAB;
        e.rs = 1'b1;
        q.push_back(e);
        cyc("ml_load_a");
        reset = 1'b1;
        q.push_back(v(4'd0, 7'd0));
        cyc("ml_reset");
        reset = 1'b0;
        q.push_back(v(4'd1, 7'd0));
        cyc("ml_refetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
